// File: rtl/elastic_pipeline.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit words under a valid/ack handshake, with bubble collapse,
// synchronous flush and an occupancy count. Optional ELASTIC_PIPELINE_DEBUG_EN exposes the raw stage registers.
module elastic_pipeline #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   request_in,
  output logic                   ack_out,
  output logic [WIDTH-1:0]       data_out,
  output logic                   request_out,
  input  logic                   ack_in,
`ifdef ELASTIC_PIPELINE_DEBUG_EN
  output logic [CNT_W-1:0]       occupancy,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data
`else
  output logic [CNT_W-1:0]       occupancy
`endif
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]            occ_q, occ_d;

  logic [DEPTH-1:0]            ready;
  logic                        ready_acc;
  logic [DEPTH-1:0]            up_vld;
  logic [DEPTH-1:0][WIDTH-1:0] up_dat;
  logic                        in_xfer, out_xfer;

  // A stage can advance if it or any stage downstream of it has a hole, or the consumer takes the last word.
  always_comb begin
    ready     = '0;
    ready_acc = ack_in;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready_acc = ~valid_q[i] | ready_acc;
      ready[i]  = ready_acc;
    end
  end

  always_comb begin
    up_vld    = '0;
    up_dat    = '0;
    up_vld[0] = request_in;
    up_dat[0] = data_in;
    for (int i = 1; i < DEPTH; i++) begin
      up_vld[i] = valid_q[i-1];
      up_dat[i] = data_q[i-1];
    end
  end

  assign ack_out     = ready[0] & ~flush & ~reset;
  assign request_out = valid_q[DEPTH-1];
  assign data_out    = data_q[DEPTH-1];
  assign occupancy   = occ_q;
  assign in_xfer     = request_in & ack_out;
  assign out_xfer    = request_out & ack_in;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    occ_d   = occ_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i]) begin
        valid_d[i] = up_vld[i];
        // Data only moves with a valid word so an emptied stage keeps its last value.
        if (up_vld[i]) begin
          data_d[i] = up_dat[i];
        end
      end
    end
    case ({in_xfer, out_xfer})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
    if (flush) begin
      valid_d = '0;
      data_d  = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

`ifdef ELASTIC_PIPELINE_DEBUG_EN
  assign stage_valid = valid_q;
  assign stage_data  = data_q;
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_elastic_pipeline;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, flush, request_in, ack_in;
  logic [WIDTH-1:0] data_in;
  wire              ack_out, request_out;
  wire [WIDTH-1:0]  data_out;
  wire [CNT_W-1:0]  occupancy;
`ifdef ELASTIC_PIPELINE_DEBUG_EN
  wire [DEPTH-1:0]       stage_valid;
  wire [DEPTH*WIDTH-1:0] stage_data;
`endif

  elastic_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .data_in(data_in), .request_in(request_in), .ack_out(ack_out),
    .data_out(data_out), .request_out(request_out), .ack_in(ack_in),
`ifdef ELASTIC_PIPELINE_DEBUG_EN
    .occupancy(occupancy), .stage_valid(stage_valid), .stage_data(stage_data)
`else
    .occupancy(occupancy)
`endif
  );

  // Reference model: FIFO of words with the number of edges since each was accepted.
  // The oldest word is never blocked, so it reaches the output DEPTH-1 edges after acceptance.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               age;
  } ent_t;

  ent_t             mq[$];
  logic [WIDTH-1:0] m_last;
  logic [WIDTH-1:0] got_q[$];
  logic [WIDTH-1:0] want_q[$];
  int               out_cyc[$];
  int               cyc;
  logic             last_in_x;

  int n_tests, n_fail;

  logic             obs_ack, obs_req, exp_ack, exp_req;
  logic [WIDTH-1:0] obs_dout, exp_dout;
  logic [CNT_W-1:0] obs_occ, exp_occ;

  function automatic void predict();
    exp_occ = CNT_W'(mq.size());
    exp_req = 1'b0;
    if (mq.size() > 0) exp_req = (mq[0].age >= DEPTH - 1);
    exp_dout = exp_req ? mq[0].d : m_last;
    exp_ack  = !reset && !flush && ((mq.size() < DEPTH) || ack_in);
  endfunction

  task automatic tick();
    logic in_x, out_x;
    ent_t e;
    predict();
    in_x  = request_in && exp_ack;
    out_x = exp_req && ack_in;
    if (out_x) begin
      got_q.push_back(data_out);
      want_q.push_back(mq[0].d);
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    last_in_x = in_x;
    if (reset || flush) begin
      mq.delete();
      m_last = '0;
    end else begin
      if (out_x) begin
        m_last = mq[0].d;
        void'(mq.pop_front());
      end
      for (int i = 0; i < mq.size(); i++) mq[i].age = mq[i].age + 1;
      if (in_x) begin
        e.d   = data_in;
        e.age = 0;
        mq.push_back(e);
      end
    end
    @(negedge clk);
    obs_ack  = ack_out;
    obs_req  = request_out;
    obs_dout = data_out;
    obs_occ  = occupancy;
    predict();
  endtask

  task automatic drain();
    request_in = 1'b0;
    flush      = 1'b0;
    ack_in     = 1'b1;
    for (int k = 0; k < 64 && mq.size() > 0; k++) tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; request_in = 1'b1; data_in = 4'h5; ack_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++; if (obs_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", obs_ack); end
      n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", obs_req); end
      n_tests++; if (obs_dout !== 4'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", obs_dout); end
      n_tests++; if (obs_occ !== exp_occ) begin n_fail++; $display("FAIL reset_occ: got %0d want %0d", obs_occ, exp_occ); end
    end
    reset = 1'b0;
    #1;
    predict();
    n_tests++; if (ack_out !== exp_ack) begin n_fail++; $display("FAIL reset_release_ack: got %b want %b", ack_out, exp_ack); end
    tick();
    n_tests++; if (obs_occ !== exp_occ) begin n_fail++; $display("FAIL reset_first_accept: got %0d want %0d", obs_occ, exp_occ); end
    drain();
  endtask

  task automatic test_latency();
    int k;
    got_q.delete(); want_q.delete();
    ack_in = 1'b1; request_in = 1'b1; data_in = 4'hA;
    tick();
    k = 1;
    request_in = 1'b0;
    n_tests++; if (obs_req !== exp_req) begin n_fail++; $display("FAIL lat_early_req: got %b want %b", obs_req, exp_req); end
    while (obs_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_tests++; if (k !== DEPTH) begin n_fail++; $display("FAIL lat_cycles: got %0d want %0d", k, DEPTH); end
    n_tests++; if (obs_dout !== 4'hA) begin n_fail++; $display("FAIL lat_data: got %h want a", obs_dout); end
    tick();
    n_tests++; if (obs_occ !== 3'd0) begin n_fail++; $display("FAIL lat_occ_after: got %0d want 0", obs_occ); end
    n_tests++; if (obs_req !== exp_req) begin n_fail++; $display("FAIL lat_req_after: got %b want %b", obs_req, exp_req); end
  endtask

  task automatic test_streaming();
    got_q.delete(); want_q.delete(); out_cyc.delete();
    ack_in = 1'b1;
    for (int v = 0; v < 16; v++) begin
      data_in = 4'(v); request_in = 1'b1;
      tick();
      n_tests++; if (obs_ack !== 1'b1) begin n_fail++; $display("FAIL stream_ack[%0d]: got %b want 1", v, obs_ack); end
      n_tests++; if (obs_occ !== exp_occ) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want %0d", v, obs_occ, exp_occ); end
      n_tests++; if (obs_req !== exp_req) begin n_fail++; $display("FAIL stream_req[%0d]: got %b want %b", v, obs_req, exp_req); end
    end
    drain();
    n_tests++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL stream_count: got %0d want 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      n_tests++; if (got_q[i] !== 4'(i)) begin n_fail++; $display("FAIL stream_word[%0d]: got %h want %h", i, got_q[i], 4'(i)); end
      n_tests++; if (out_cyc[i] !== out_cyc[0] + i) begin n_fail++; $display("FAIL stream_rate[%0d]: got cycle %0d want %0d", i, out_cyc[i], out_cyc[0] + i); end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held;
    got_q.delete(); want_q.delete();
    ack_in = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      data_in = 4'(v); request_in = 1'b1;
      tick();
    end
    data_in = 4'h5;
    #1;
    n_tests++; if (ack_out !== 1'b0) begin n_fail++; $display("FAIL bp_full_ack: got %b want 0", ack_out); end
    n_tests++; if (obs_occ !== 3'd4) begin n_fail++; $display("FAIL bp_full_occ: got %0d want 4", obs_occ); end
    held = obs_dout;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++; if (obs_req !== 1'b1) begin n_fail++; $display("FAIL bp_stall_req[%0d]: got %b want 1", k, obs_req); end
      n_tests++; if (obs_dout !== 4'h1 || obs_dout !== held) begin n_fail++; $display("FAIL bp_stall_data[%0d]: got %h want 1", k, obs_dout); end
      n_tests++; if (obs_occ !== exp_occ) begin n_fail++; $display("FAIL bp_stall_occ[%0d]: got %0d want %0d", k, obs_occ, exp_occ); end
    end
    ack_in = 1'b1;
    tick();
    n_tests++; if (obs_occ !== 3'd4) begin n_fail++; $display("FAIL bp_swap_occ: got %0d want 4", obs_occ); end
    n_tests++; if (obs_dout !== 4'h2) begin n_fail++; $display("FAIL bp_next_data: got %h want 2", obs_dout); end
    drain();
    n_tests++; if (got_q.size() !== 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      n_tests++; if (got_q[i] !== 4'(i + 1)) begin n_fail++; $display("FAIL bp_word[%0d]: got %h want %h", i, got_q[i], 4'(i + 1)); end
    end
  endtask

  task automatic test_flush();
    logic [WIDTH-1:0] fill [3];
    fill[0] = 4'h9; fill[1] = 4'hB; fill[2] = 4'hC;
    got_q.delete(); want_q.delete();
    ack_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = fill[i]; request_in = 1'b1;
      tick();
    end
    n_tests++; if (obs_occ !== 3'd3) begin n_fail++; $display("FAIL flush_fill_occ: got %0d want 3", obs_occ); end
    flush = 1'b1; data_in = 4'h7; request_in = 1'b1;
    #1;
    n_tests++; if (ack_out !== 1'b0) begin n_fail++; $display("FAIL flush_ack: got %b want 0", ack_out); end
    tick();
    n_tests++; if (obs_occ !== 3'd0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", obs_occ); end
    n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL flush_req: got %b want 0", obs_req); end
    n_tests++; if (obs_dout !== 4'h0) begin n_fail++; $display("FAIL flush_dout: got %h want 0", obs_dout); end
    flush = 1'b0; request_in = 1'b0; ack_in = 1'b1;
    tick();
    data_in = 4'h3; request_in = 1'b1;
    tick();
    drain();
    n_tests++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL flush_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_tests++; if (got_q[0] !== 4'h3) begin n_fail++; $display("FAIL flush_next_word: got %h want 3", got_q[0]); end
    end
  endtask

  task automatic test_reset_midstream();
    got_q.delete(); want_q.delete();
    ack_in = 1'b0;
    for (int v = 0; v < 3; v++) begin
      data_in = 4'(4'hE - v); request_in = 1'b1;
      tick();
    end
    request_in = 1'b0;
    n_tests++; if (obs_occ !== 3'd3) begin n_fail++; $display("FAIL rst_mid_occ_before: got %0d want 3", obs_occ); end
    reset = 1'b1; ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    tick();
    n_tests++; if (obs_occ !== 3'd0) begin n_fail++; $display("FAIL rst_mid_occ: got %0d want 0", obs_occ); end
    n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b want 0", obs_req); end
    n_tests++; if (obs_dout !== 4'h0) begin n_fail++; $display("FAIL rst_mid_dout: got %h want 0", obs_dout); end
`ifdef ELASTIC_PIPELINE_DEBUG_EN
    n_tests++; if (stage_valid !== '0) begin n_fail++; $display("FAIL rst_mid_stage_valid: got %b want 0", stage_valid); end
    n_tests++; if (stage_data !== '0) begin n_fail++; $display("FAIL rst_mid_stage_data: got %h want 0", stage_data); end
`endif
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ack_in = ~ack_in;
      tick();
      n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale[%0d]: got %b want 0", k, obs_req); end
    end
    n_tests++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL rst_mid_delivered: got %0d want 0", got_q.size()); end
  endtask

  task automatic test_random();
    got_q.delete(); want_q.delete();
    request_in = 1'b0; last_in_x = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!request_in || last_in_x) begin
        request_in = ($urandom_range(0, 9) < 6);
        data_in    = WIDTH'($urandom);
      end
      ack_in = ($urandom_range(0, 9) < 7);
      flush  = ($urandom_range(0, 49) == 0);
      tick();
      n_tests++; if (obs_occ !== exp_occ) begin n_fail++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", c, obs_occ, exp_occ); end
      n_tests++; if (obs_req !== exp_req) begin n_fail++; $display("FAIL rnd_req[%0d]: got %b want %b", c, obs_req, exp_req); end
      n_tests++; if (obs_dout !== exp_dout) begin n_fail++; $display("FAIL rnd_dout[%0d]: got %h want %h", c, obs_dout, exp_dout); end
      n_tests++; if (obs_ack !== exp_ack) begin n_fail++; $display("FAIL rnd_ack[%0d]: got %b want %b", c, obs_ack, exp_ack); end
    end
    drain();
    n_tests++; if (got_q.size() !== want_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), want_q.size()); end
    for (int i = 0; i < got_q.size() && i < want_q.size(); i++) begin
      n_tests++; if (got_q[i] !== want_q[i]) begin n_fail++; $display("FAIL rnd_word[%0d]: got %h want %h", i, got_q[i], want_q[i]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; m_last = '0; last_in_x = 1'b0;
    reset = 1'b1; flush = 1'b0; request_in = 1'b0; ack_in = 1'b0; data_in = '0;
    test_reset();
    test_latency();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
